// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller.
// MC_ADDI_EN enables the addi execute/writeback states.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // mr_gate marks enables and done that only fire once memory completes.
  typedef struct packed {
    logic       iord;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       done;
    logic       mr_gate;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic logic op_supported(input logic [5:0] op);
    logic v_ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: v_ok = 1'b1;
`ifdef MC_ADDI_EN
      OP_ADDI: v_ok = 1'b1;
`endif
      default: v_ok = 1'b0;
    endcase
    return v_ok;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control-word decoder for mc_control_fsm.
// MC_ADDI_EN adds the addi execute/writeback control words.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  // Per-state Moore control word; unlisted fields stay at their idle value.
  always_comb begin
    o_ctrl = CTRL_IDLE;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.mr_gate   = 1'b1;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_SHIMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: o_ctrl.iord = 1'b1;
      S_MEMWRITE: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.done      = 1'b1;
        o_ctrl.mr_gate   = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.done       = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.done      = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.done      = 1'b1;
      end
`endif
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_src    = PCSRC_ALUOUT;
        o_ctrl.branch    = 1'b1;
        o_ctrl.done      = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_src   = PCSRC_JUMP;
        o_ctrl.pc_write = 1'b1;
        o_ctrl.done     = 1'b1;
      end
      default: o_ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: state register, next-state, mem_ready gating, PCEn.
// Define MC_ADDI_EN to support addi; otherwise opcode 001000 is illegal.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_zero,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCEn,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t r_state;
  logic   r_is_sw;
  ctrl_t  w_ctrl;
  logic   w_gate;
  logic   w_run;

  // State register and next-state logic; the sw/lw choice is latched in DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_is_sw <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          r_is_sw <= (opcode == OP_SW);
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
`ifdef MC_ADDI_EN
            OP_ADDI:      r_state <= S_ADDIEX;
`endif
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= r_is_sw ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= mem_ready ? S_MEMWB : S_MEMREAD;
        S_MEMWRITE: r_state <= mem_ready ? S_FETCH : S_MEMWRITE;
        S_EXECUTE:  r_state <= S_ALUWB;
`ifdef MC_ADDI_EN
        S_ADDIEX:   r_state <= S_ADDIWB;
`endif
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  mc_ctrl_outdec u_outdec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Reset holds the state at FETCH, so only enables and pulses need forcing low.
  assign w_run  = ~reset;
  assign w_gate = mem_ready | ~w_ctrl.mr_gate;

  assign IorD     = w_ctrl.iord;
  assign ALUSrcA  = w_ctrl.alu_src_a;
  assign RegDst   = w_ctrl.reg_dst;
  assign MemtoReg = w_ctrl.mem_to_reg;
  assign ALUSrcB  = w_ctrl.alu_src_b;
  assign ALUOp    = w_ctrl.alu_op;
  assign PCSrc    = w_ctrl.pc_src;

  assign IRWrite    = w_ctrl.ir_write & w_gate & w_run;
  assign PCWrite    = w_ctrl.pc_write & w_gate & w_run;
  assign MemWrite   = w_ctrl.mem_write & w_run;
  assign RegWrite   = w_ctrl.reg_write & w_run;
  assign instr_done = w_ctrl.done & w_gate & w_run;
  assign PCEn       = PCWrite | (w_ctrl.branch & alu_zero & w_run);
  assign illegal_op = (r_state == S_DECODE) & ~op_supported(opcode) & w_run;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized scoreboard bench for mc_control_fsm: per-instruction phase lists
// from a reference model feed expected control words to a negedge monitor.
module tb_mc_control_fsm;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_J    = 6'b000010;

  logic       clk = 1'b0;
  logic       reset, mem_ready, alu_zero;
  logic [5:0] opcode;
  logic       IorD, ALUSrcA, RegDst, MemtoReg;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       IRWrite, PCWrite, MemWrite, RegWrite, PCEn, instr_done, illegal_op;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .IorD(IorD), .ALUSrcA(ALUSrcA), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .PCEn(PCEn), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  typedef struct {
    bit          rst;
    bit          mr;
    bit          az;
    logic [5:0]  op;
    logic [16:0] exp;
  } stim_t;

  stim_t       stim_q[$];
  string       stag_q[$];
  logic [16:0] exp_q[$];
  string       etag_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          g_rand = 1'b0;

  function automatic logic [16:0] cw(bit iord, bit asa, bit rd, bit m2r,
      logic [1:0] asb, logic [1:0] aop, logic [1:0] pcs, bit irw, bit pcw,
      bit mw, bit rw, bit pce, bit done, bit ill);
    return {iord, asa, rd, m2r, asb, aop, pcs, irw, pcw, mw, rw, pce, done, ill};
  endfunction

  // Expected outputs for one cycle of a named phase, straight from the state table.
  function automatic logic [16:0] model(string ph, bit mr, bit az);
    if (ph == "RESET")    return cw(0,0,0,0,2'b01,2'b00,2'b00,0,0,0,0,0,0,0);
    if (ph == "FETCH")    return cw(0,0,0,0,2'b01,2'b00,2'b00,mr,mr,0,0,mr,0,0);
    if (ph == "DECODE")   return cw(0,0,0,0,2'b11,2'b00,2'b00,0,0,0,0,0,0,0);
    if (ph == "ILLEGAL")  return cw(0,0,0,0,2'b11,2'b00,2'b00,0,0,0,0,0,0,1);
    if (ph == "MEMADR" || ph == "ADDIEX")
                          return cw(0,1,0,0,2'b10,2'b00,2'b00,0,0,0,0,0,0,0);
    if (ph == "MEMREAD")  return cw(1,0,0,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,0);
    if (ph == "MEMWRITE") return cw(1,0,0,0,2'b00,2'b00,2'b00,0,0,1,0,0,mr,0);
    if (ph == "MEMWB")    return cw(0,0,0,1,2'b00,2'b00,2'b00,0,0,0,1,0,1,0);
    if (ph == "EXECUTE")  return cw(0,1,0,0,2'b00,2'b10,2'b00,0,0,0,0,0,0,0);
    if (ph == "ALUWB")    return cw(0,0,1,0,2'b00,2'b00,2'b00,0,0,0,1,0,1,0);
    if (ph == "ADDIWB")   return cw(0,0,0,0,2'b00,2'b00,2'b00,0,0,0,1,0,1,0);
    if (ph == "BRANCH")   return cw(0,1,0,0,2'b00,2'b01,2'b01,0,0,0,0,az,1,0);
    if (ph == "JUMP")     return cw(0,0,0,0,2'b00,2'b00,2'b10,0,1,0,0,1,1,0);
    return 17'h1ffff;
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit rmr();
    return g_rand ? rbit() : 1'b1;
  endfunction

  task automatic add(string ph, bit rst, bit mr, bit az, logic [5:0] op);
    stim_t s;
    s.rst = rst; s.mr = mr; s.az = az; s.op = op;
    s.exp = rst ? model("RESET", mr, az) : model(ph, mr, az);
    stim_q.push_back(s);
    stag_q.push_back(ph);
  endtask

  // Non-decode cycles carry a junk opcode so only DECODE's sample matters.
  task automatic one(string ph);
    add(ph, 1'b0, rmr(), rbit(), 6'($urandom_range(0, 63)));
  endtask

  task automatic waitph(string ph, int waits);
    for (int i = 0; i < waits; i++) add(ph, 1'b0, 1'b0, rbit(), 6'($urandom_range(0, 63)));
    add(ph, 1'b0, 1'b1, rbit(), 6'($urandom_range(0, 63)));
  endtask

  task automatic instr(logic [5:0] op, int fw, int mw, bit az_br);
    bit legal_addi;
`ifdef MC_ADDI_EN
    legal_addi = 1'b1;
`else
    legal_addi = 1'b0;
`endif
    waitph("FETCH", fw);
    if (op == T_LW) begin
      add("DECODE", 1'b0, rmr(), rbit(), op);
      one("MEMADR"); waitph("MEMREAD", mw); one("MEMWB");
    end else if (op == T_SW) begin
      add("DECODE", 1'b0, rmr(), rbit(), op);
      one("MEMADR"); waitph("MEMWRITE", mw);
    end else if (op == T_R) begin
      add("DECODE", 1'b0, rmr(), rbit(), op);
      one("EXECUTE"); one("ALUWB");
    end else if (op == T_BEQ) begin
      add("DECODE", 1'b0, rmr(), rbit(), op);
      add("BRANCH", 1'b0, rmr(), az_br, 6'($urandom_range(0, 63)));
    end else if (op == T_ADDI && legal_addi) begin
      add("DECODE", 1'b0, rmr(), rbit(), op);
      one("ADDIEX"); one("ADDIWB");
    end else if (op == T_J) begin
      add("DECODE", 1'b0, rmr(), rbit(), op);
      one("JUMP");
    end else begin
      add("ILLEGAL", 1'b0, rmr(), rbit(), op);
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = T_LW;
      1: op = T_SW;
      2: op = T_R;
      3: op = T_BEQ;
      4: op = T_ADDI;
      5: op = T_J;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (op == T_LW || op == T_SW || op == T_R || op == T_BEQ ||
               op == T_ADDI || op == T_J)
          op = 6'($urandom_range(0, 63));
      end
    endcase
    return op;
  endfunction

  // Monitor: every cycle is an output sample; pop and compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e, a;
      string t;
      e = exp_q.pop_front();
      t = etag_q.pop_front();
      a = {IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, ALUOp, PCSrc,
           IRWrite, PCWrite, MemWrite, RegWrite, PCEn, instr_done, illegal_op};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s @%0t: got %b expected %b", t, $time, a, e);
      end
    end
  end

  initial begin
    stim_t s;
    string t;
    reset = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0; opcode = 6'd0;
    for (int i = 0; i < 3; i++) add("RESET", 1'b1, rbit(), rbit(), 6'd0);
    g_rand = 1'b0;
    instr(T_LW, 0, 0, 1'b0);
    instr(T_SW, 0, 3, 1'b0);
    instr(T_BEQ, 0, 0, 1'b1);
    instr(T_BEQ, 0, 0, 1'b0);
    instr(6'b111111, 0, 0, 1'b0);
    instr(T_ADDI, 0, 0, 1'b0);
    instr(T_J, 0, 0, 1'b0);
    instr(T_R, 0, 0, 1'b0);
    waitph("FETCH", 0);
    add("DECODE", 1'b0, 1'b1, 1'b0, T_LW);
    one("MEMADR");
    add("MEMREAD", 1'b1, 1'b1, 1'b1, T_LW);
    add("MEMREAD", 1'b1, 1'b1, 1'b0, T_LW);
    instr(T_LW, 0, 0, 1'b0);
    g_rand = 1'b1;
    for (int i = 0; i < 80; i++)
      instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3), rbit());

    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      s = stim_q.pop_front();
      t = stag_q.pop_front();
      reset = s.rst; mem_ready = s.mr; alu_zero = s.az; opcode = s.op;
      exp_q.push_back(s.exp);
      etag_q.push_back(t);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
